// File: rtl/hazard_sb.sv
// Hazard/flush controller: forwarding, stalls, long-op scoreboard, exception flush FSM.
// Latency: outputs combinational from state+inputs; scoreboard/FSM update on clk edge.
// Backpressure: mem > ex > dep > ifetch stall priority; exception flush overrides all.
// Optional HAZARD_PERF_CNT_EN adds cnt_mem/cnt_ex/cnt_dep/cnt_exc stall-class counters.
module hazard_sb #(
    parameter int REG_AW       = 5,
    parameter int LONG_MAX     = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall_req,
    input  logic              d_stall_req,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] wregD,
    input  logic              regwriteD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              long_reqD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              long_issueE,
    input  logic              long_busyE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              is_exceptM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              long_done,
    input  logic [REG_AW-1:0] long_wreg,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              pc_redirect,
    output logic              long_full
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_mem,
    output logic [CNT_W-1:0]  cnt_ex,
    output logic [CNT_W-1:0]  cnt_dep,
    output logic [CNT_W-1:0]  cnt_exc
`endif
);

    localparam int NREG = 1 << REG_AW;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t            r_state;
    logic [3:0]        r_fcnt;
    logic [3:0]        r_cnt;
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;

    logic w_lwstall, w_branchstall, w_sb_hit, w_dep_stall;
    logic w_exc_now, w_in_flush, w_override, w_issue;

    // Forwarding: M has priority over W, register 0 is never forwarded
    always_comb begin
        forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
        forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if ((rsE != '0) && (rsE == writeregM) && regwriteM)      forwardaE = 2'b10;
        else if ((rsE != '0) && (rsE == writeregW) && regwriteW) forwardaE = 2'b01;
        if ((rtE != '0) && (rtE == writeregM) && regwriteM)      forwardbE = 2'b10;
        else if ((rtE != '0) && (rtE == writeregW) && regwriteW) forwardbE = 2'b01;
    end

    assign w_lwstall     = ((rsD == rtE) || (rtD == rtE)) && memtoregE;
    assign w_branchstall = (branchD && regwriteE && ((writeregE == rsD) || (writeregE == rtD)))
                         | (branchD && memtoregM && ((writeregM == rsD) || (writeregM == rtD)))
                         | (jrD && regwriteE && (writeregE == rsD))
                         | (jrD && memtoregM && (writeregM == rsD));

    assign long_full   = (r_cnt == 4'(LONG_MAX));
    assign w_sb_hit    = r_busy[rsD] | r_busy[rtD] | (regwriteD & r_busy[wregD]);
    assign w_dep_stall = w_lwstall | w_branchstall | w_sb_hit | (long_reqD & long_full);

    assign w_in_flush = (r_state == S_FLUSH);
    assign w_exc_now  = (r_state == S_IDLE) && is_exceptM;
    assign w_override = w_in_flush | w_exc_now;

    always_comb begin
        stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
        flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
        pc_redirect = 1'b0;
        if (w_in_flush) begin
            {flushD, flushE, flushM, flushW} = 4'b1111;
            stallF = i_stall_req;
            stallD = i_stall_req;
        end else if (w_exc_now) begin
            {flushD, flushE, flushM, flushW} = 4'b1111;
            pc_redirect = 1'b1;
        end else if (d_stall_req) begin
            {stallF, stallD, stallE, stallM} = 4'b1111;
            flushW = 1'b1;
        end else if (long_busyE) begin
            {stallF, stallD, stallE} = 3'b111;
            flushM = 1'b1;
        end else if (w_dep_stall) begin
            {stallF, stallD} = 2'b11;
            flushE = 1'b1;
        end else if (i_stall_req) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end
    end

    assign w_issue = long_issueE & ~stallE & ~flushE;

    // Clear applied before set so a same-cycle set on the same register wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (long_done)
            w_busy_nxt[long_wreg] = 1'b0;
        if (w_issue && (writeregE != '0))
            w_busy_nxt[writeregE] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            case ({w_issue, long_done})
                2'b10: if (r_cnt != 4'(LONG_MAX)) r_cnt <= r_cnt + 4'd1;
                2'b01: if (r_cnt != 4'd0)         r_cnt <= r_cnt - 4'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (is_exceptM && (FLUSH_CYCLES > 1)) begin
                        r_state <= S_FLUSH;
                        r_fcnt  <= 4'(FLUSH_CYCLES - 1);
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt <= 4'd1) begin
                        r_state <= S_IDLE;
                        r_fcnt  <= '0;
                    end else begin
                        r_fcnt <= r_fcnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_fcnt  <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_mem <= '0;
            cnt_ex  <= '0;
            cnt_dep <= '0;
            cnt_exc <= '0;
        end else begin
            if (!w_override && d_stall_req)
                cnt_mem <= cnt_mem + 1'b1;
            if (!w_override && !d_stall_req && long_busyE)
                cnt_ex <= cnt_ex + 1'b1;
            if (!w_override && !d_stall_req && !long_busyE && w_dep_stall)
                cnt_dep <= cnt_dep + 1'b1;
            if (w_exc_now)
                cnt_exc <= cnt_exc + 1'b1;
        end
    end
`else
    logic [31:0] w_cnt_w_unused;
    assign w_cnt_w_unused = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb with LONG_MAX=2, FLUSH_CYCLES=3.
module tb_hazard_sb;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_stall_req, d_stall_req;
    logic [4:0] rsD, rtD, wregD;
    logic       regwriteD, branchD, jrD, long_reqD;
    logic [4:0] rsE, rtE, writeregE;
    logic       regwriteE, memtoregE, long_issueE, long_busyE;
    logic [4:0] writeregM;
    logic       regwriteM, memtoregM, is_exceptM;
    logic [4:0] writeregW;
    logic       regwriteW;
    logic       long_done;
    logic [4:0] long_wreg;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushM, flushW;
    logic       pc_redirect, long_full;
    logic [9:0] ctl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_sb #(.REG_AW(5), .LONG_MAX(2), .FLUSH_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_stall_req(i_stall_req), .d_stall_req(d_stall_req),
        .rsD(rsD), .rtD(rtD), .wregD(wregD),
        .regwriteD(regwriteD), .branchD(branchD), .jrD(jrD), .long_reqD(long_reqD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .long_issueE(long_issueE), .long_busyE(long_busyE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .is_exceptM(is_exceptM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .long_done(long_done), .long_wreg(long_wreg),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .pc_redirect(pc_redirect), .long_full(long_full)
    );

    // {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW,pc_redirect,long_full}
    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
                  pc_redirect, long_full};

    localparam logic [9:0] C_NONE  = 10'b0000000000;
    localparam logic [9:0] C_DEP   = 10'b1100010000;
    localparam logic [9:0] C_DEPF  = 10'b1100010001;
    localparam logic [9:0] C_MEM   = 10'b1111000100;
    localparam logic [9:0] C_EX    = 10'b1110001000;
    localparam logic [9:0] C_IF    = 10'b1000100000;
    localparam logic [9:0] C_EXC   = 10'b0000111110;
    localparam logic [9:0] C_FL    = 10'b0000111100;
    localparam logic [9:0] C_FLI   = 10'b1100111100;

    task automatic clear_inputs();
        i_stall_req = 0; d_stall_req = 0;
        rsD = 0; rtD = 0; wregD = 0; regwriteD = 0; branchD = 0; jrD = 0; long_reqD = 0;
        rsE = 0; rtE = 0; writeregE = 0; regwriteE = 0; memtoregE = 0;
        long_issueE = 0; long_busyE = 0;
        writeregM = 0; regwriteM = 0; memtoregM = 0; is_exceptM = 0;
        writeregW = 0; regwriteW = 0; long_done = 0; long_wreg = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE);
        end
        n_checks++;
        if ({forwardaD, forwardbD, forwardaE, forwardbE} !== 6'b0) begin
            n_fail++; $display("FAIL reset_fwd got=%b exp=000000",
                               {forwardaD, forwardbD, forwardaE, forwardbE});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        rsD = 2; rtE = 2; writeregE = 2; memtoregE = 1; regwriteE = 1;
        #1;
        n_checks++;
        if (ctl !== C_DEP) begin
            n_fail++; $display("FAIL lw_stall got=%b exp=%b", ctl, C_DEP);
        end
        tick();
        clear_inputs();
        rsD = 2; rsE = 2; writeregM = 2; regwriteM = 1; memtoregM = 1;
        #1;
        n_checks++;
        if ({ctl, forwardaE, forwardaD} !== {C_NONE, 2'b10, 1'b1}) begin
            n_fail++; $display("FAIL lw_fwd got=%b/%b/%b exp=%b/10/1", ctl, forwardaE, forwardaD, C_NONE);
        end
    endtask

    task automatic test_forward();
        do_reset();
        rsE = 3; rtE = 4; rtD = 4; writeregM = 4; regwriteM = 1; writeregW = 3; regwriteW = 1;
        #1;
        n_checks++;
        if ({forwardaE, forwardbE, forwardbD} !== {2'b01, 2'b10, 1'b1}) begin
            n_fail++; $display("FAIL fwd_mw got=%b%b%b exp=01101", forwardaE, forwardbE, forwardbD);
        end
        writeregM = 3;
        #1;
        n_checks++;
        if ({forwardaE, forwardbE} !== 4'b1000) begin
            n_fail++; $display("FAIL fwd_prio got=%b%b exp=1000", forwardaE, forwardbE);
        end
        rsE = 0; rtE = 0; writeregM = 0; writeregW = 0;
        #1;
        n_checks++;
        if ({forwardaE, forwardbE} !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_r0 got=%b%b exp=0000", forwardaE, forwardbE);
        end
        clear_inputs();
        branchD = 1; rsD = 6; regwriteE = 1; writeregE = 6;
        #1;
        n_checks++;
        if (ctl !== C_DEP) begin
            n_fail++; $display("FAIL branch_stall got=%b exp=%b", ctl, C_DEP);
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        long_issueE = 1; writeregE = 5;
        tick();
        clear_inputs();
        rsD = 5;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_DEP) begin
                n_fail++; $display("FAIL sb_hold[%0d] got=%b exp=%b", i, ctl, C_DEP);
            end
            tick();
        end
        long_done = 1; long_wreg = 5;
        #1;
        n_checks++;
        if (ctl !== C_DEP) begin
            n_fail++; $display("FAIL sb_done_cycle got=%b exp=%b", ctl, C_DEP);
        end
        tick();
        long_done = 0; long_wreg = 0;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL sb_release got=%b exp=%b", ctl, C_NONE);
        end
    endtask

    task automatic test_long_full();
        do_reset();
        long_issueE = 1; writeregE = 3;
        tick();
        writeregE = 4;
        tick();
        clear_inputs();
        long_reqD = 1;
        #1;
        n_checks++;
        if (ctl !== C_DEPF) begin
            n_fail++; $display("FAIL full_stall got=%b exp=%b", ctl, C_DEPF);
        end
        long_done = 1; long_wreg = 3;
        tick();
        long_done = 0; long_wreg = 0;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL full_release got=%b exp=%b", ctl, C_NONE);
        end
        long_issueE = 1; writeregE = 10;
        tick();
        long_issueE = 0; writeregE = 0;
        #1;
        n_checks++;
        if (ctl !== C_DEPF) begin
            n_fail++; $display("FAIL full_count1 got=%b exp=%b", ctl, C_DEPF);
        end
    endtask

    task automatic test_priority();
        do_reset();
        d_stall_req = 1; memtoregE = 1; rtE = 2; rsD = 2;
        long_issueE = 1; writeregE = 11;
        #1;
        n_checks++;
        if (ctl !== C_MEM) begin
            n_fail++; $display("FAIL prio_mem got=%b exp=%b", ctl, C_MEM);
        end
        tick();
        long_issueE = 0; writeregE = 0;
        long_busyE = 1; d_stall_req = 0;
        #1;
        n_checks++;
        if (ctl !== C_EX) begin
            n_fail++; $display("FAIL prio_ex got=%b exp=%b", ctl, C_EX);
        end
        long_busyE = 0;
        #1;
        n_checks++;
        if (ctl !== C_DEP) begin
            n_fail++; $display("FAIL prio_dep got=%b exp=%b", ctl, C_DEP);
        end
        clear_inputs();
        i_stall_req = 1;
        #1;
        n_checks++;
        if (ctl !== C_IF) begin
            n_fail++; $display("FAIL prio_if got=%b exp=%b", ctl, C_IF);
        end
        i_stall_req = 0; rsD = 11;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL stalled_issue_dropped got=%b exp=%b", ctl, C_NONE);
        end
    endtask

    task automatic test_exception();
        do_reset();
        is_exceptM = 1; d_stall_req = 1;
        #1;
        n_checks++;
        if (ctl !== C_EXC) begin
            n_fail++; $display("FAIL exc_entry got=%b exp=%b", ctl, C_EXC);
        end
        tick();
        is_exceptM = 0; d_stall_req = 0; i_stall_req = 1;
        #1;
        n_checks++;
        if (ctl !== C_FLI) begin
            n_fail++; $display("FAIL exc_flush2 got=%b exp=%b", ctl, C_FLI);
        end
        tick();
        i_stall_req = 0; is_exceptM = 1;
        #1;
        n_checks++;
        if (ctl !== C_FL) begin
            n_fail++; $display("FAIL exc_flush3 got=%b exp=%b", ctl, C_FL);
        end
        tick();
        is_exceptM = 0;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL exc_end got=%b exp=%b", ctl, C_NONE);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        long_issueE = 1; writeregE = 6;
        tick();
        writeregE = 7; long_done = 1; long_wreg = 7;
        tick();
        clear_inputs();
        rsD = 7;
        #1;
        n_checks++;
        if (ctl !== C_DEP) begin
            n_fail++; $display("FAIL same_busy7 got=%b exp=%b", ctl, C_DEP);
        end
        rsD = 0; long_reqD = 1;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL same_count got=%b exp=%b", ctl, C_NONE);
        end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        long_issueE = 1; writeregE = 9;
        tick();
        clear_inputs();
        is_exceptM = 1;
        tick();
        is_exceptM = 0; rst = 1;
        #1;
        n_checks++;
        if (ctl !== C_FL) begin
            n_fail++; $display("FAIL rst_flush_cycle got=%b exp=%b", ctl, C_FL);
        end
        tick();
        rst = 0;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL rst_in_flush got=%b exp=%b", ctl, C_NONE);
        end
        rsD = 9;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++; $display("FAIL rst_sb_clear got=%b exp=%b", ctl, C_NONE);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_scoreboard();
        test_long_full();
        test_priority();
        test_exception();
        test_same_cycle();
        test_reset_in_flush();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_sb.md
Name: hazard_sb

Overview:
- Parametrised next-generation hazard and flush controller for the 5-stage MIPS pipeline.
- Keeps the M/W forwarding and the load-use and branch stalls of the current unit.
- Adds a per-register scoreboard for non-blocking long-latency ops (divider, long loads) with a bounded outstanding-op counter.
- Adds memory-wait stalls and a sequenced, multi-cycle exception flush FSM with PC-redirect strobe.

Parameters:
- REG_AW, 5, register index width; scoreboard holds 2**REG_AW busy bits.
- LONG_MAX, 2, maximum outstanding long ops (1..15).
- FLUSH_CYCLES, 1, cycles flushD/E/M/W stay high per exception (1..15).
- CNT_W, 32, perf counter width (only with HAZARD_PERF_CNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_stall_req  in  1  instruction SRAM wait.
- d_stall_req  in  1  data SRAM wait (instruction in M).
- rsD, rtD, wregD  in  REG_AW  D-stage sources and destination.
- regwriteD, branchD, jrD, long_reqD  in  1  D-stage attributes; long_reqD means the instruction is a long op.
- rsE, rtE, writeregE  in  REG_AW  E-stage registers.
- regwriteE, memtoregE  in  1  E-stage attributes.
- long_issueE  in  1  the E instruction starts a non-blocking long op to writeregE.
- long_busyE  in  1  a blocking E unit needs more cycles.
- writeregM  in  REG_AW  M-stage destination.
- regwriteM, memtoregM, is_exceptM  in  1  M-stage attributes.
- writeregW  in  REG_AW  W-stage destination.
- regwriteW  in  1  W-stage write enable.
- long_done  in  1  long op result written this cycle.
- long_wreg  in  REG_AW  destination of the completed long op.
- forwardaD, forwardbD  out  1  forward from M to the D comparator.
- forwardaE, forwardbE  out  2  E operand source: 00 regfile, 01 W, 10 M.
- stallF, stallD, stallE, stallM  out  1  stage hold signals.
- flushD, flushE, flushM, flushW  out  1  stage bubble signals.
- pc_redirect  out  1  load the exception vector into the PC.
- long_full  out  1  outstanding count equals LONG_MAX.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset state: busy bits all 0, outstanding count 0, FSM IDLE, flush counter 0. All outputs are combinational from state and inputs, so all are 0 after reset with inputs at 0.
- Forwarding: identical rules to the current unit (M priority over W, register 0 never forwarded), widened to REG_AW.
- sb_hit = busy[rsD] | busy[rtD] | (regwriteD & busy[wregD]). busy[0] is never set.
- dep_stall = lwstall | branchstall | sb_hit | (long_reqD & long_full). lwstall and branchstall use the current-unit equations.
- ex_stall = long_busyE.
- mem_stall = d_stall_req.
- Stall priority, when not in exception override:
  - mem_stall: stallF/D/E/M=1, flushW=1.
  - else ex_stall: stallF/D/E=1, flushM=1.
  - else dep_stall: stallF/D=1, flushE=1.
  - else i_stall_req: stallF=1, flushD=1.
- Scoreboard set: busy[writeregE] set when long_issueE & ~stallE & ~flushE & writeregE!=0.
- Scoreboard clear: busy[long_wreg] cleared when long_done.
- Same register set and cleared in one cycle: set wins.
- long_done with long_wreg=0 only decrements the count.
- Outstanding counter: +1 on accepted issue, -1 on long_done. Both in one cycle leaves it unchanged. A done at count 0 is ignored (no underflow). The count never exceeds LONG_MAX.
- FSM, IDLE:
  - is_exceptM=1 → combinationally flushD/E/M/W=1, pc_redirect=1, stallF..stallM=0.
  - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in IDLE.
- FSM, FLUSH:
  - flushD/E/M/W=1, stallE/M=0, stallF=stallD=i_stall_req, pc_redirect=0.
  - is_exceptM ignored; counter decrements; at 1 → IDLE.
- Outstanding long ops are not cancelled by an exception; their completions still clear busy bits.
- rst in any state → IDLE and clear the scoreboard on the next edge.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs cnt_mem, cnt_ex, cnt_dep, cnt_exc (CNT_W each).
  - Each counts cycles its stall class was the active one; cnt_exc counts exception entries.
  - Counters wrap modulo 2**CNT_W and reset to 0.
- Undefined: these ports and counters do not exist; other behaviour is identical.

Test Plan:
- lw $2 in E, rsD=2 → stallF=stallD=flushE=1 for 1 cycle; next cycle forwardaE=10.
- long_issueE writereg=5, then rsD=5 for 10 cycles → stallD=1 throughout; long_done long_wreg=5 → stallD=0 the following cycle.
- LONG_MAX=2: two issues, then long_reqD=1 → long_full=1 and stallD=1; one long_done → released next cycle, count=1.
- d_stall_req=1 together with dep_stall=1 → stallF/D/E/M=1, flushW=1, flushE=0.
- FLUSH_CYCLES=3, is_exceptM pulse → pc_redirect=1 for 1 cycle and flushD/E/M/W=1 for exactly 3 cycles; a second is_exceptM during FLUSH has no effect.
- Same-cycle long_issueE and long_done on reg 7 → busy[7]=1 and count unchanged; rst during FLUSH → all outputs 0 next cycle.
